// File: rtl/mtl_ball_pkg.sv
// mtl_ball_pkg
// Shared definitions for the ball coordinate scheduler.
//   N_BALLS, XW, YW, IDXW : default slot count and field widths
//   ball_pos_t            : packed (x, y) coordinate pair
//   sched_state_t         : commit FSM states
package mtl_ball_pkg;

    localparam int unsigned N_BALLS = 10;
    localparam int unsigned XW      = 10;
    localparam int unsigned YW      = 9;
    localparam int unsigned IDXW    = 4;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } ball_pos_t;

    typedef enum logic [1:0] {
        IDLE,
        DIRTY,
        HOLD,
        COMMIT
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Two-requester round-robin arbiter with an enable gate on the grants.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (pointer -> requester a)
//   en            : grants are forced low while en = 0
//   req_a, req_b  : requests
//   gnt_a, gnt_b  : grants (one-hot or zero, never without the matching request)
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    // 0: requester a wins the next contested cycle, 1: requester b wins
    logic ptr_q, ptr_d;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        ptr_d = ptr_q;
        if (en) begin
            if (req_a && req_b) begin
                gnt_a = ~ptr_q;
                gnt_b = ptr_q;
                // Only contested grants move the pointer
                ptr_d = ~ptr_q;
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mtl_ball_scheduler.sv
// mtl_ball_scheduler
// Double-buffered ball coordinate table for mtl_display_controller. Writes from
// two requesters land in a shadow bank; the shadow bank is copied to the
// active bank only at frame end so a frame never shows a half-updated table.
// Ports:
//   iCLK, iRST          : pixel clock, synchronous active-high reset
//   iEndFrame           : one-cycle frame-end pulse from the display controller
//   iA_*/iB_*           : write requests (Valid, Idx, X, Y) from host link / engine
//   oA_Ready, oB_Ready  : combinational grants; a write transfers on Valid && Ready
//   iBatch              : host batch open, defers the commit
//   oX, oY              : active bank, slot i = oX[i] / oY[i]
//   oCommit             : high in the cycle the active bank is loaded
//   oLate               : high while a commit is being deferred
//   oFrameCnt, oSkipCnt : saturating statistics counters
// Configuration: define BALL_SCHED_STATS_EN to enable the statistics counters;
// otherwise oFrameCnt/oSkipCnt are tied to zero.
module mtl_ball_scheduler #(
    parameter int unsigned N_BALLS = 10,
    parameter int unsigned XW      = 10,
    parameter int unsigned YW      = 9,
    parameter int unsigned IDXW    = 4
) (
    input  logic                          iCLK,
    input  logic                          iRST,
    input  logic                          iEndFrame,
    input  logic                          iA_Valid,
    input  logic [IDXW-1:0]               iA_Idx,
    input  logic [XW-1:0]                 iA_X,
    input  logic [YW-1:0]                 iA_Y,
    output logic                          oA_Ready,
    input  logic                          iB_Valid,
    input  logic [IDXW-1:0]               iB_Idx,
    input  logic [XW-1:0]                 iB_X,
    input  logic [YW-1:0]                 iB_Y,
    output logic                          oB_Ready,
    input  logic                          iBatch,
    output logic [N_BALLS-1:0][XW-1:0]    oX,
    output logic [N_BALLS-1:0][YW-1:0]    oY,
    output logic                          oCommit,
    output logic                          oLate,
    output logic [15:0]                   oFrameCnt,
    output logic [15:0]                   oSkipCnt
);

    import mtl_ball_pkg::*;

    sched_state_t state_q, state_d;

    logic [N_BALLS-1:0][XW-1:0] sh_x_q, sh_x_d, act_x_q;
    logic [N_BALLS-1:0][YW-1:0] sh_y_q, sh_y_d, act_y_q;

    logic            arb_en;
    logic            gnt_a, gnt_b;
    logic            wr_acc, wr_hit;
    logic [IDXW-1:0] wr_idx;
    logic [XW-1:0]   wr_x;
    logic [YW-1:0]   wr_y;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign arb_en = ~iRST && (state_q != COMMIT);

    rr_arbiter2 u_arb (
        .clk   (iCLK),
        .rst   (iRST),
        .en    (arb_en),
        .req_a (iA_Valid),
        .req_b (iB_Valid),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    assign oA_Ready = gnt_a;
    assign oB_Ready = gnt_b;

    always_comb begin
        wr_idx = gnt_b ? iB_Idx : iA_Idx;
        wr_x   = gnt_b ? iB_X   : iA_X;
        wr_y   = gnt_b ? iB_Y   : iA_Y;
        wr_acc = gnt_a | gnt_b;
        // Out-of-range slots are accepted but dropped
        wr_hit = wr_acc && (32'(wr_idx) < N_BALLS);
    end

    // ------------------------------------------------------------------
    // Shadow bank
    // ------------------------------------------------------------------
    always_comb begin
        sh_x_d = sh_x_q;
        sh_y_d = sh_y_q;
        for (int unsigned i = 0; i < N_BALLS; i++) begin
            if (wr_hit && (32'(wr_idx) == i)) begin
                sh_x_d[i] = wr_x;
                sh_y_d[i] = wr_y;
            end
        end
    end

    // ------------------------------------------------------------------
    // Commit FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        oCommit = 1'b0;
        oLate   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Frame end is ignored here; nothing to commit yet
                if (wr_hit) begin
                    state_d = DIRTY;
                end
            end
            DIRTY: begin
                if (iEndFrame) begin
                    state_d = iBatch ? HOLD : COMMIT;
                end
            end
            HOLD: begin
                oLate = 1'b1;
                // Only a frame boundary may release the hold
                if (iEndFrame && !iBatch) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                oCommit = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
            sh_x_q  <= '0;
            sh_y_q  <= '0;
            act_x_q <= '0;
            act_y_q <= '0;
        end else begin
            state_q <= state_d;
            sh_x_q  <= sh_x_d;
            sh_y_q  <= sh_y_d;
            if (state_q == COMMIT) begin
                act_x_q <= sh_x_q;
                act_y_q <= sh_y_q;
            end
        end
    end

    assign oX = act_x_q;
    assign oY = act_y_q;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef BALL_SCHED_STATS_EN
    logic [15:0] frame_cnt_q, skip_cnt_q;
    logic        skip_evt;

    // A frame end that enters or stays in HOLD is a skipped commit
    assign skip_evt = iEndFrame && iBatch && ((state_q == DIRTY) || (state_q == HOLD));

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            frame_cnt_q <= '0;
            skip_cnt_q  <= '0;
        end else begin
            if (iEndFrame && (frame_cnt_q != 16'hFFFF)) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (skip_evt && (skip_cnt_q != 16'hFFFF)) begin
                skip_cnt_q <= skip_cnt_q + 16'd1;
            end
        end
    end

    assign oFrameCnt = frame_cnt_q;
    assign oSkipCnt  = skip_cnt_q;
`else
    assign oFrameCnt = 16'd0;
    assign oSkipCnt  = 16'd0;
`endif

endmodule

// File: tb/tb_mtl_ball_scheduler.sv
// tb_mtl_ball_scheduler
// Directed stimulus with a commit scoreboard: each frame end that should
// commit pushes the expected bank contents; a monitor pops on oCommit and
// compares the active bank one cycle later.
module tb_mtl_ball_scheduler;

    localparam int NB = 10;

    typedef logic [NB-1:0][9:0] xbank_t;
    typedef logic [NB-1:0][8:0] ybank_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ef;
    logic        a_valid, b_valid;
    logic [3:0]  a_idx, b_idx;
    logic [9:0]  a_x, b_x;
    logic [8:0]  a_y, b_y;
    logic        a_ready, b_ready;
    logic        batch;
    xbank_t      ox;
    ybank_t      oy;
    logic        o_commit, o_late;
    logic [15:0] frame_cnt, skip_cnt;

    always #5 clk = ~clk;

    mtl_ball_scheduler dut (
        .iCLK      (clk),
        .iRST      (rst),
        .iEndFrame (ef),
        .iA_Valid  (a_valid),
        .iA_Idx    (a_idx),
        .iA_X      (a_x),
        .iA_Y      (a_y),
        .oA_Ready  (a_ready),
        .iB_Valid  (b_valid),
        .iB_Idx    (b_idx),
        .iB_X      (b_x),
        .iB_Y      (b_y),
        .oB_Ready  (b_ready),
        .iBatch    (batch),
        .oX        (ox),
        .oY        (oy),
        .oCommit   (o_commit),
        .oLate     (o_late),
        .oFrameCnt (frame_cnt),
        .oSkipCnt  (skip_cnt)
    );

    int checks   = 0;
    int failures = 0;
    int frames   = 0;
    int skips    = 0;

    xbank_t mx;
    ybank_t my;
    xbank_t exp_x_q[$];
    ybank_t exp_y_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int v);
`ifdef BALL_SCHED_STATS_EN
        return 32'(v);
`else
        return 32'(v) & 32'd0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [3:0] idx, input logic [9:0] x, input logic [8:0] y);
        if (idx < 4'(NB)) begin
            mx[idx] = x;
            my[idx] = y;
        end
    endtask

    task automatic wr_a(input logic [3:0] idx, input logic [9:0] x, input logic [8:0] y);
        a_valid = 1'b1;
        a_idx   = idx;
        a_x     = x;
        a_y     = y;
        #1;
        chk("a_ready_single", a_ready, 1);
        model_write(idx, x, y);
        step();
        a_valid = 1'b0;
    endtask

    task automatic end_frame(input bit expect_commit);
        ef = 1'b1;
        if (expect_commit) begin
            exp_x_q.push_back(mx);
            exp_y_q.push_back(my);
        end
        frames++;
        step();
        ef = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        chk("a_ready_in_reset", a_ready, 0);
        chk("b_ready_in_reset", b_ready, 0);
        step();
        step();
        rst     = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        batch   = 1'b0;
        mx      = '0;
        my      = '0;
        frames  = 0;
        skips   = 0;
    endtask

    task automatic chk_cleared();
        for (int i = 0; i < NB; i++) begin
            chk("reset_x", 32'(ox[i]), 0);
            chk("reset_y", 32'(oy[i]), 0);
        end
        chk("reset_commit", o_commit, 0);
        chk("reset_late", o_late, 0);
        chk("reset_frame_cnt", frame_cnt, 0);
        chk("reset_skip_cnt", skip_cnt, 0);
    endtask

    // Commit monitor
    initial begin
        xbank_t ex;
        ybank_t ey;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && o_commit === 1'b1) begin
                if (exp_x_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_commit: got oCommit=1 expected 0");
                end else begin
                    ex = exp_x_q.pop_front();
                    ey = exp_y_q.pop_front();
                    chk("commit_a_ready", a_ready, 0);
                    chk("commit_b_ready", b_ready, 0);
                    @(negedge clk);
                    for (int i = 0; i < NB; i++) begin
                        chk("commit_bank_x", 32'(ox[i]), 32'(ex[i]));
                        chk("commit_bank_y", 32'(oy[i]), 32'(ey[i]));
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        ef = 0; batch = 0; rst = 1;
        a_valid = 0; a_idx = 0; a_x = 0; a_y = 0;
        b_valid = 0; b_idx = 0; b_x = 0; b_y = 0;
        mx = '0; my = '0;
        step();
        do_reset();
        chk_cleared();

        // Single write, then commit
        wr_a(4'd0, 10'd400, 9'd200);
        end_frame(1);
        chk("commit_pulse_t1", o_commit, 1);
        step();
        chk("slot0_x", 32'(ox[0]), 400);
        chk("slot0_y", 32'(oy[0]), 200);
        chk("slot1_x", 32'(ox[1]), 0);
        chk("frame_cnt_1", frame_cnt, exp_cnt(1));

        // Contested writes: grants A, B, A, B
        for (int k = 0; k < 4; k++) begin
            a_valid = 1'b1;
            b_valid = 1'b1;
            a_idx   = 4'(1 + k);
            a_x     = 10'(110 + k);
            a_y     = 9'(60 + k);
            b_idx   = 4'(5 + k);
            b_x     = 10'(205 + k);
            b_y     = 9'(105 + k);
            #1;
            chk("rr_a_ready", a_ready, (k % 2 == 0) ? 1 : 0);
            chk("rr_b_ready", b_ready, (k % 2 == 0) ? 0 : 1);
            if (k % 2 == 0) model_write(a_idx, a_x, a_y);
            else            model_write(b_idx, b_x, b_y);
            step();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        end_frame(1);
        step();
        step();
        chk("rr_slot1_x", 32'(ox[1]), 110);
        chk("rr_slot6_x", 32'(ox[6]), 206);
        chk("rr_slot2_x", 32'(ox[2]), 0);

        // Batch defers commit across two frame ends
        wr_a(4'd4, 10'd44, 9'd34);
        batch = 1'b1;
        end_frame(0);
        skips++;
        chk("batch_late_1", o_late, 1);
        chk("batch_no_commit_1", o_commit, 0);
        end_frame(0);
        skips++;
        chk("batch_late_2", o_late, 1);
        batch = 1'b0;
        step();
        step();
        step();
        chk("hold_no_midframe_commit", o_commit, 0);
        chk("hold_late_after_drop", o_late, 1);
        chk("skip_cnt_2", skip_cnt, exp_cnt(skips));
        end_frame(1);
        chk("batch_commit", o_commit, 1);
        chk("batch_late_clear", o_late, 0);
        step();
        step();
        chk("batch_slot4_x", 32'(ox[4]), 44);

        // Write in the same cycle as the frame end
        wr_a(4'd7, 10'd77, 9'd67);
        a_valid = 1'b1;
        a_idx   = 4'd3;
        a_x     = 10'd333;
        a_y     = 9'd233;
        #1;
        chk("same_cycle_ready", a_ready, 1);
        model_write(4'd3, 10'd333, 9'd233);
        end_frame(1);
        b_valid = 1'b1;
        #1;
        chk("commit_cycle_a_ready", a_ready, 0);
        chk("commit_cycle_b_ready", b_ready, 0);
        chk("same_cycle_commit", o_commit, 1);
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();
        step();
        chk("same_cycle_slot3_x", 32'(ox[3]), 333);
        chk("same_cycle_slot3_y", 32'(oy[3]), 233);

        // Out-of-range index is accepted and dropped
        wr_a(4'd12, 10'd500, 9'd300);
        end_frame(0);
        chk("oor_no_commit", o_commit, 0);
        chk("oor_late", o_late, 0);
        chk("frame_cnt_oor", frame_cnt, exp_cnt(frames));
        step();
        step();

        // Reset while holding dirty data
        wr_a(4'd9, 10'd90, 9'd80);
        batch = 1'b1;
        end_frame(0);
        chk("pre_reset_late", o_late, 1);
        do_reset();
        chk_cleared();
        end_frame(0);
        chk("post_reset_no_commit", o_commit, 0);
        step();
        step();

        chk("pending_commits", 32'(exp_x_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
